pipelined_subtractor: RTL
=========================

// Module: pipelined_subtractor
// PURPOSE
//  Pipelined WIDTH-bit two's-complement subtractor: diff = a - b - bin, built from
//  SLICE-bit ripple slices with one register stage per slice (STAGES = WIDTH/SLICE).
//  It is the inverse-operation companion to the pipelined adder on the same datapath.
//  Valid/ready handshakes are used on the input and output sides, with a global stall.
// PARAMETERS
//  WIDTH  8  operand/result width; must be a multiple of SLICE
//  SLICE  4  bits per pipeline slice; STAGES = WIDTH/SLICE (default 2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a/b/bin valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in (1 subtracts an extra 1)
//  out_valid  out  1      diff/bout/ovf valid
//  out_ready  in   1      downstream accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow-out: 1 when unsigned a < b + bin
//  ovf        out  1      signed overflow of a - b - bin
// BEHAVIOUR
//  - Arithmetic per slice k: {c_out, d} = a_k + ~b_k + c_in, carry c = ~borrow.
//    Slice 0 c_in = ~bin. bout = ~c_out of the top slice.
//    ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
//  - Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational).
//    When en = 0, every stage register (data, carry, valid) holds its value.
//    Bubbles are not collapsed.
//  - Transfer on input when in_valid && in_ready. Transfer on output when
//    out_valid && out_ready.
//  - Stage k (k = 0..STAGES-1) computes slice k combinationally from the stage k-1
//    register (or from the ports for k = 0). It registers the partial diff, the
//    carry, the untouched upper operand slices and a valid bit.
//  - The last stage register drives diff/bout/ovf/out_valid directly. Outputs are
//    registered.
//  - Latency: STAGES cycles from input transfer to out_valid (2 at default) when
//    out_ready stays 1. Throughput is 1 result per cycle.
//  - Ordering: results leave in acceptance order. No result is dropped or duplicated.
//  - Stall: while out_valid && !out_ready, diff/bout/ovf are stable and in_ready = 0.
//  - Reset (async assert, any time, including mid-operation):
//    - All valid bits clear immediately, so out_valid = 0 and in_ready = 1.
//    - diff = 0, bout = 0, ovf = 0.
//    - In-flight operations are discarded. Data registers may also reset to 0.
//  - Release of rst is synchronous to clk; the first input is accepted on the first
//    rising edge after release.
//  - Wrap-around: results are modulo 2^WIDTH, with no saturation.
//    Example: 0x00 - 0x01 -> 0xFF, bout = 1.
//  - Simultaneous input and output transfer in the same cycle is legal and required
//    for full throughput.
// STRUCTURE
//  - Shared package arith_pkg: SLICE_W constant, a stage_t struct typedef
//    {valid, carry, partial diff, remaining a/b slices}, and the ovf helper function.
//  - One sub-module: sub_slice (SLICE-bit combinational a + ~b + cin -> d, cout),
//    instantiated STAGES times via generate.
//  - Stage registers live in this module, gated by en.
// TESTING
//  1. a=0x50, b=0x20, bin=0, out_ready=1 -> 2 cycles later diff=0x30, bout=0, ovf=0.
//  2. a=0x20, b=0x50, bin=0 -> diff=0xD0, bout=1, ovf=0.
//     a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
//  3. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. a=0x10, b=0x01 -> diff=0x0F,
//     exercising the inter-slice borrow.
//  4. Back-to-back inputs (0x09-0x03, 0x09-0x04, 0x09-0x05), in_valid held 1 ->
//     out_valid for 3 consecutive cycles with diff 0x06, 0x05, 0x04 in order.
//  5. Stall: 2 results in flight, out_ready=0 for 4 cycles -> in_ready=0, diff held.
//     Then out_ready=1 -> both results emitted in order, with none lost.
//  6. rst pulsed mid-stream between clock edges with 2 results in flight ->
//     out_valid drops immediately, outputs 0. Next accepted op 0x05-0x02 -> diff=0x03.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined add/subtract datapath: slice width,
// the per-stage register record and the signed-overflow helper.
package arith_pkg;

    localparam int unsigned SLICE_W = 4;
    localparam int unsigned DATA_W  = 8;

    // One pipeline stage register. The full operands travel along so each later
    // stage can pick its own slice and the last stage still has both sign bits.
    typedef struct packed {
        logic              valid;
        logic              carry;  // carry = ~borrow out of the slices done so far
        logic [DATA_W-1:0] diff;   // partial difference; low slices filled in
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } stage_t;

    // Signed overflow of a - b: operand signs differ and the result sign left a's.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice: {cout_o, d_o} = a_i + ~b_i + cin_i.
module sub_slice
    import arith_pkg::*;
#(
    parameter int unsigned W = SLICE_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] d_o,
    output logic         cout_o
);

    logic [W-1:0] b_n;
    logic [W:0]   sum;

    // Invert at slice width first so the zero-extension cannot pollute the carry bit
    always_comb begin
        b_n = ~b_i;
        sum = {1'b0, a_i} + {1'b0, b_n} + {{W{1'b0}}, cin_i};
        d_o    = sum[W-1:0];
        cout_o = sum[W];
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined two's-complement subtractor: diff = a - b - bin, one SLICE-bit ripple
// slice per register stage, valid/ready on both sides with a global stall.
module pipelined_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    // Carry resets to 1 so the idle output shows no borrow.
    localparam stage_t StageRst = stage_t'({1'b0, 1'b1, {(3 * DATA_W){1'b0}}});

    // stage_t is sized from the package, so the operand width is pinned to it
    if (WIDTH != DATA_W || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("pipelined_subtractor: WIDTH must equal DATA_W and be a multiple of SLICE");
    end

    stage_t           st_q   [STAGES];
    stage_t           st_d   [STAGES];
    stage_t           src    [STAGES];
    logic [SLICE-1:0] sl_d   [STAGES];
    logic             sl_cout[STAGES];
    logic             en;

    // Whole pipe advances unless a valid result is stuck at the output
    always_comb begin
        en       = !st_q[STAGES-1].valid || out_ready;
        in_ready = en;
    end

    // Stage inputs: ports feed stage 0, each later stage reads its predecessor
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].carry = ~bin;
        src[0].a     = a;
        src[0].b     = b;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        sub_slice #(
            .W(SLICE)
        ) u_sub_slice (
            .a_i   (src[k].a[k*SLICE +: SLICE]),
            .b_i   (src[k].b[k*SLICE +: SLICE]),
            .cin_i (src[k].carry),
            .d_o   (sl_d[k]),
            .cout_o(sl_cout[k])
        );
    end

    // Next stage contents: slice k result merged in, or hold everything on stall
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (en) begin
                st_d[k]                         = src[k];
                st_d[k].diff[k*SLICE +: SLICE]  = sl_d[k];
                st_d[k].carry                   = sl_cout[k];
            end else begin
                st_d[k] = st_q[k];
            end
        end
    end

    // Stage registers; async reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= StageRst;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    // Outputs come straight from the last stage register
    always_comb begin
        out_valid = st_q[STAGES-1].valid;
        diff      = st_q[STAGES-1].diff;
        bout      = ~st_q[STAGES-1].carry;
        ovf       = sub_ovf(st_q[STAGES-1].a[WIDTH-1], st_q[STAGES-1].b[WIDTH-1],
                            st_q[STAGES-1].diff[WIDTH-1]);
    end

    // Only the operand sign bits matter once the last slice is done
    logic unused_low_ops;
    assign unused_low_ops = ^{st_q[STAGES-1].a[WIDTH-2:0], st_q[STAGES-1].b[WIDTH-2:0]};

endmodule
